waveform_uart_tx: RTL
=====================

WAVEFORM_UART_TX -- requirements
Module: waveform_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200).
REQ-002 SHALL have parameter NUM_SAMPLES, default 32, number of waveform samples per frame.
REQ-003 SHALL have parameter SAMPLE_W, default 14, sample width in bits.
REQ-004 SHALL have one clock, clk; reset is synchronous and active-high.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request to transmit one frame; sampled only in IDLE.
REQ-008 waveform  input  NUM_SAMPLES x SAMPLE_W (unpacked array)  captured waveform; index 0 is the oldest sample.
REQ-009 tx  output  1  UART serial line, 8N1, idle high.
REQ-010 busy  output  1  high from start acceptance until done.
REQ-011 done  output  1  one-cycle pulse when the frame is complete.

Function
REQ-012 SHALL accept start only in IDLE, and SHALL snapshot all NUM_SAMPLES samples into an internal buffer in the same edge.
REQ-013 SHALL ignore start while busy, and SHALL NOT let waveform changes after acceptance affect the frame.
REQ-014 Frame SHALL be header byte 0xA5, then for i = 0..NUM_SAMPLES-1 the high byte {2'b00, s[13:8]} followed by the low byte s[7:0]; 65 bytes at default parameters.
REQ-015 Each byte SHALL be sent as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1); each bit holds tx for exactly CLKS_PER_BIT cycles.
REQ-016 SHALL leave zero idle cycles between the end of one stop bit and the next start bit within a frame.
REQ-017 tx SHALL go low (header start bit) exactly 2 cycles after the edge that accepts start.
REQ-018 busy SHALL rise at the accepting edge (registered, visible the next cycle).
REQ-019 done SHALL pulse for one cycle immediately after the last stop bit completes; busy SHALL fall in the same cycle.
REQ-020 Frame FSM states SHALL be IDLE, HEADER, SAMP_HI, SAMP_LO, FINISH; transitions:
  - IDLE -> HEADER on start.
  - HEADER -> SAMP_HI after the byte is handed off.
  - SAMP_HI -> SAMP_LO.
  - SAMP_LO -> SAMP_HI, incrementing the index, or SAMP_LO -> FINISH when index = NUM_SAMPLES-1.
  - FINISH -> IDLE when the byte engine is idle.
REQ-021 Sample index counter width SHALL be $clog2(NUM_SAMPLES) and SHALL NOT wrap during a frame.
REQ-022 A start present in the cycle done pulses SHALL be ignored; a start asserted one cycle later SHALL begin a new frame.

Reset
REQ-023 On reset, within one cycle: tx=1, busy=0, done=0, FSM=IDLE, bit counters and index = 0.
REQ-024 Reset mid-byte SHALL abort the frame with no partial continuation; tx SHALL be high the cycle after reset is sampled.
REQ-025 The internal buffer is not reset.

Structure
REQ-026 Shared package waveform_pkg SHALL hold the header constant 0xA5, SAMPLE_W, NUM_SAMPLES defaults and the frame-state enum typedef.
REQ-027 SHALL instantiate one sub-module, uart_tx_byte: 8N1 serializer with data[7:0] and valid in, ready out and tx out; it accepts a byte when valid&&ready and asserts ready during its final stop-bit cycle to enable gapless streaming.

Verification (CLKS_PER_BIT=4 in sim)
REQ-028 Reset held 3 cycles -> tx=1, busy=0, done=0 throughout and after.
REQ-029 waveform[0]=0x3FFF, [1]=0x0000, rest 0x1234, start pulse -> bytes A5 3F FF 00 00 12 34 ... (65 bytes); done exactly 2600 cycles after tx first falls.
REQ-030 Bit timing: every bit exactly 4 cycles, no gap between bytes, LSB first (0xA5 observed as 1,0,1,0,0,1,0,1).
REQ-031 start re-pulsed mid-frame and waveform overwritten with 0x0000 after acceptance -> frame unchanged, single done pulse.
REQ-032 Reset asserted during byte 10 -> tx=1 next cycle, busy=0, no done; new start -> complete correct 65-byte frame.
REQ-033 start held high continuously -> back-to-back frames, each preceded by exactly one IDLE cycle after done, all 65-byte correct.

Source files
------------

// File: rtl/waveform_pkg.sv
// Shared constants and frame-state type for the waveform UART transmitter.
package waveform_pkg;

    localparam logic [7:0]  HEADER_BYTE     = 8'hA5;
    localparam int unsigned SAMPLE_W_DEF    = 14;
    localparam int unsigned NUM_SAMPLES_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_SAMP_HI = 3'd2,
        ST_SAMP_LO = 3'd3,
        ST_FINISH  = 3'd4
    } frame_state_t;

    // High transmitted byte of a sample: upper bits above bit 7, zero-padded.
    function automatic logic [7:0] sample_hi(input logic [15:0] s);
        return s[15:8];
    endfunction

    // Low transmitted byte of a sample.
    function automatic logic [7:0] sample_lo(input logic [15:0] s);
        return s[7:0];
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; ready rises in the last stop-bit cycle so bytes stream gaplessly.
module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int unsigned    CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] B_IDLE  = 2'd0;
    localparam logic [1:0] B_START = 2'd1;
    localparam logic [1:0] B_DATA  = 2'd2;
    localparam logic [1:0] B_STOP  = 2'd3;

    logic [1:0]       st, st_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic             last_c;
    logic             line_c;

    assign last_c = (cnt == CNT_LAST);
    assign ready  = (st == B_IDLE) || ((st == B_STOP) && last_c);

    // Next-state and line level for the bit engine.
    always_comb begin
        st_n      = st;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        line_c    = 1'b1;
        case (st)
            B_IDLE: begin
                if (valid) begin
                    st_n    = B_START;
                    cnt_n   = '0;
                    shreg_n = data;
                end
            end
            B_START: begin
                line_c = 1'b0;
                if (last_c) begin
                    st_n      = B_DATA;
                    cnt_n     = '0;
                    bit_idx_n = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            B_DATA: begin
                line_c = shreg[0];
                if (last_c) begin
                    cnt_n   = '0;
                    shreg_n = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        st_n = B_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                line_c = 1'b1;
                if (last_c) begin
                    cnt_n = '0;
                    if (valid) begin
                        st_n    = B_START;
                        shreg_n = data;
                    end else begin
                        st_n = B_IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
        endcase
    end

    // Engine state and registered serial line.
    always_ff @(posedge clk) begin
        if (reset) begin
            st      <= B_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            st      <= st_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            tx      <= line_c;
        end
    end

endmodule

// File: rtl/waveform_uart_tx.sv
// Streams a snapshot of a captured waveform over UART as a header plus hi/lo sample bytes.
module waveform_uart_tx
    import waveform_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned NUM_SAMPLES  = NUM_SAMPLES_DEF,
    parameter int unsigned SAMPLE_W     = SAMPLE_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [SAMPLE_W-1:0] waveform [NUM_SAMPLES],
    output logic                tx,
    output logic                busy,
    output logic                done
);

    localparam int unsigned      IDX_W    = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

    frame_state_t        state, state_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic                armed, armed_n;
    logic                busy_n, done_n;
    logic                accept_c;
    logic                byte_valid, byte_ready;
    logic [7:0]          byte_data;
    logic [15:0]         cur_sample;
    logic [SAMPLE_W-1:0] buf_q [NUM_SAMPLES];

    // A start coinciding with the done pulse is deliberately not taken.
    assign accept_c   = (state == ST_IDLE) && start && !done;
    assign cur_sample = 16'(buf_q[idx]);

    // Snapshot of the waveform at acceptance; not reset.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            buf_q <= waveform;
        end
    end

    // Frame sequencing and byte hand-off to the serializer.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        armed_n    = armed;
        busy_n     = busy;
        done_n     = 1'b0;
        byte_valid = 1'b0;
        byte_data  = HEADER_BYTE;
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    state_n = ST_HEADER;
                    idx_n   = '0;
                    armed_n = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            ST_HEADER: begin
                byte_valid = 1'b1;
                byte_data  = HEADER_BYTE;
                if (byte_ready) begin
                    state_n = ST_SAMP_HI;
                end
            end
            ST_SAMP_HI: begin
                byte_valid = 1'b1;
                byte_data  = sample_hi(cur_sample);
                if (byte_ready) begin
                    state_n = ST_SAMP_LO;
                end
            end
            ST_SAMP_LO: begin
                byte_valid = 1'b1;
                byte_data  = sample_lo(cur_sample);
                if (byte_ready) begin
                    if (idx == LAST_IDX) begin
                        state_n = ST_FINISH;
                    end else begin
                        state_n = ST_SAMP_HI;
                        idx_n   = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                // ready marks the last stop-bit cycle; the engine is idle one cycle later.
                if (armed) begin
                    state_n = ST_IDLE;
                    armed_n = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else if (byte_ready) begin
                    armed_n = 1'b1;
                end
            end
        endcase
    end

    // Frame state register and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            idx   <= '0;
            armed <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            armed <= armed_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk  (clk),
        .reset(reset),
        .data (byte_data),
        .valid(byte_valid),
        .ready(byte_ready),
        .tx   (tx)
    );

endmodule
